cache_arbiter: RTL and testbench
================================

# cache_arbiter

Round-robin arbiter that shares one request-ID channel of a cache slave port between `n` upstream requesters, such as the L1 I-cache and D-cache master ports feeding one L2 channel. It latches a single winner and holds the grant until downstream accepts that request. Downstream response, miss, offset and read-data signals go to every requester, and each requester matches its own IDs. The block does not rewrite request IDs: requester ID ranges are disjoint by construction.

## Interface
Parameters:
- `n`, 2, number of upstream requesters (2..8)
- `blk`, 64, cache line size in bytes

Ports (ID value 0 means idle):
- `clk`  in  1  clock
- `rstn`  in  1  reset, asynchronous, active-low
- `u_rqst`  in  n×8  upstream request ID
- `u_trsc`  in  n×8  coherency transaction
- `u_strb`  in  n×blk  write strobe
- `u_addr`  in  n×64  physical address
- `u_wdat`  in  n×blk×8  write data
- `u_resp`  out  n×8  response ID, broadcast
- `u_miss`  out  n×8  miss ID, broadcast
- `u_ofst`  out  n×64  line offset, broadcast
- `u_rdat`  out  n×blk×8  read data, broadcast
- `d_rqst`  out  8  downstream request ID
- `d_trsc`  out  8  coherency transaction
- `d_strb`  out  blk  write strobe
- `d_addr`  out  64  physical address
- `d_wdat`  out  blk×8  write data
- `d_resp`  in  8  downstream response ID
- `d_miss`  in  8  downstream miss ID
- `d_ofst`  in  64  line offset
- `d_rdat`  in  blk×8  read data
- `busy`  out  1  grant held (status)

## Operation
- Registered state is `st` (IDLE or GRANT), `gnt` (log2(n) bits), `ptr` (round-robin pointer, log2(n) bits) and `gid` (latched granted request ID, 8 bits).
- IDLE:
  - The winner is the first requester i with `u_rqst[i]`≠0, searching from `ptr` upward modulo n.
  - If a winner exists: `gnt`←i, `gid`←`u_rqst[i]`, `st`←GRANT.
- GRANT:
  - `d_*` is driven combinationally from `u_*[gnt]`.
  - `d_rqst` = `u_rqst[gnt]` only while `u_rqst[gnt]`==`gid`; otherwise it is 0.
- Release from GRANT:
  - Release when `d_resp`==`gid` and `gid`≠0. This covers both an accepted miss (`d_miss`≠0) and a hit completion.
  - Also release when `u_rqst[gnt]`≠`gid`, i.e. the requester withdrew or changed its request (flush).
  - On release: `st`←IDLE, `ptr`←`gnt`+1 modulo n, `gid`←0.
- Release and re-arbitration never happen in the same cycle. A requester's next request is granted no earlier than the cycle after IDLE is entered.
- Broadcast: `u_resp[i]`=`d_resp`, `u_miss[i]`=`d_miss`, `u_ofst[i]`=`d_ofst`, `u_rdat[i]`=`d_rdat` for all i, every cycle, independent of `st`. Late miss callbacks therefore reach the owner after its grant has ended.
- `busy` = (`st`==GRANT).
- Reset (`rstn`=0, asynchronous): `st`=IDLE, `gnt`=0, `ptr`=0, `gid`=0. Resulting outputs: `d_rqst`=0 and `busy`=0. `d_trsc`, `d_strb`, `d_addr`, `d_wdat` equal the requester-0 inputs but are don't-care while `d_rqst`=0. Broadcast outputs follow the downstream inputs.

## Timing
- Arbitration latency is 1 cycle. A request that arrives in cycle t, with the block IDLE and no higher-priority contender, appears on `d_rqst` in cycle t+1.
- Minimum occupancy per grant is 2 cycles: 1 IDLE cycle plus at least 1 GRANT cycle. If `d_resp` matches in the first GRANT cycle, the block is IDLE at t+2.
- Simultaneous withdraw and `d_resp`==`gid` in one cycle: a single release; `ptr` advances once.
- Simultaneous requests from all n ports: each port is served exactly once in n grants, in order `ptr`, `ptr`+1, and so on. No port waits more than n−1 grants.
- Downstream holds off `d_resp` during its fill/stale cycles. The arbiter keeps the grant and keeps driving `d_rqst` unchanged until it gets a response.
- Reset asserted mid-GRANT: `d_rqst` drops to 0 immediately (asynchronously). No response is tracked after reset.

## Structure
- A shared package (`mmu_pkg`) holds `id_t` (logic [7:0]) and the `ID_IDLE`=0 constant.
- A single sub-module, `rr_pick`, is combinational: inputs are the request vector and `ptr`; outputs are the winner index and a valid flag. The FSM, latches and muxes stay in `cache_arbiter`.
- Expected size is about 150–200 lines.

## Test plan
- Single request, with n=2: `u_rqst[1]`=8'h21 at cycle 0 → `d_rqst`=8'h21 at cycle 1. Drive `d_resp`=8'h21 at cycle 3 → `busy`=0 at cycle 4 and `ptr`=0.
- Contention: both ports request at cycle 0, with IDs 8'h11 and 8'h21 and `ptr`=0 → 8'h11 is granted first. After its `d_resp`, 8'h21 is granted the cycle after IDLE, then `ptr` returns to 0.
- Miss ack then callback: `d_resp`=8'h11 with `d_miss`=8'h05 releases the grant. Five cycles later, `d_resp`=8'h05 with data appears on every `u_resp` and `u_rdat`, while port 1 holds the grant.
- Flush withdraw: port 0 is granted 8'h11 and drops `u_rqst[0]` to 0 → `d_rqst`=0 the same cycle, IDLE next cycle. A late `d_resp`=8'h11 is broadcast and does not disturb the new grant.
- Fairness soak with n=4: all ports request continuously for 400 cycles, with downstream `d_resp` arriving 2–5 cycles after `d_rqst` → grant counts differ by at most 1, and the maximum wait is 3 grants.
- Reset mid-GRANT: `rstn` is pulled low between clock edges → `d_rqst`=0 and `busy`=0 before the next edge. After release, port 0 is arbitrated first.

Source files
------------

// File: rtl/mmu_pkg.sv
// Shared request-ID type and arbiter state encoding used by the cache
// slave-port arbiter and its helpers.
package mmu_pkg;

  typedef logic [7:0] id_t;

  localparam id_t ID_IDLE = 8'h00;

  typedef enum logic {
    ST_IDLE,
    ST_GRANT
  } arb_st_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or after
// i_ptr, wrapping modulo n.
module rr_pick #(
  parameter int unsigned n  = 2,
  parameter int unsigned GW = $clog2(n)
) (
  input  logic [n-1:0]  i_req,
  input  logic [GW-1:0] i_ptr,
  output logic [GW-1:0] o_idx,
  output logic          o_vld
);

  localparam int unsigned PW = GW + 1;

  logic [PW-1:0] w_pos;

  always_comb begin
    o_idx = '0;
    o_vld = 1'b0;
    w_pos = '0;
    for (int unsigned k = 0; k < n; k++) begin
      // one extra bit so ptr+k cannot overflow before the modulo fold
      w_pos = {1'b0, i_ptr} + PW'(k);
      if (w_pos >= PW'(n)) w_pos = w_pos - PW'(n);
      if (!o_vld && i_req[w_pos[GW-1:0]]) begin
        o_vld = 1'b1;
        o_idx = w_pos[GW-1:0];
      end
    end
  end

endmodule

// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one cache slave request channel between n
// requesters; holds a single grant until downstream responds or it is withdrawn.
module cache_arbiter
  import mmu_pkg::*;
#(
  parameter int unsigned n   = 2,
  parameter int unsigned blk = 64
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [n-1:0][7:0]           u_rqst,
  input  logic [n-1:0][7:0]           u_trsc,
  input  logic [n-1:0][blk-1:0]       u_strb,
  input  logic [n-1:0][63:0]          u_addr,
  input  logic [n-1:0][blk*8-1:0]     u_wdat,
  output logic [n-1:0][7:0]           u_resp,
  output logic [n-1:0][7:0]           u_miss,
  output logic [n-1:0][63:0]          u_ofst,
  output logic [n-1:0][blk*8-1:0]     u_rdat,
  output logic [7:0]                  d_rqst,
  output logic [7:0]                  d_trsc,
  output logic [blk-1:0]              d_strb,
  output logic [63:0]                 d_addr,
  output logic [blk*8-1:0]            d_wdat,
  input  logic [7:0]                  d_resp,
  input  logic [7:0]                  d_miss,
  input  logic [63:0]                 d_ofst,
  input  logic [blk*8-1:0]            d_rdat,
  output logic                        busy
);

  localparam int unsigned   GW   = $clog2(n);
  localparam logic [GW-1:0] LAST = GW'(n - 1);

  arb_st_e       r_st;
  logic [GW-1:0] r_gnt;
  logic [GW-1:0] r_ptr;
  id_t           r_gid;

  logic [n-1:0]  w_req;
  logic [GW-1:0] w_win;
  logic          w_vld;
  id_t           w_cur;
  logic          w_hold;
  logic          w_rel;

  always_comb begin
    w_req = '0;
    for (int unsigned i = 0; i < n; i++) begin
      w_req[i] = (u_rqst[i] != ID_IDLE);
    end
  end

  rr_pick #(
    .n  (n),
    .GW (GW)
  ) u_pick (
    .i_req (w_req),
    .i_ptr (r_ptr),
    .o_idx (w_win),
    .o_vld (w_vld)
  );

  assign w_cur  = u_rqst[r_gnt];
  assign w_hold = (w_cur == r_gid);
  // a response to the held ID and a withdraw/flush in the same cycle is one release
  assign w_rel  = ((d_resp == r_gid) && (r_gid != ID_IDLE)) || !w_hold;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_st  <= ST_IDLE;
      r_gnt <= '0;
      r_ptr <= '0;
      r_gid <= ID_IDLE;
    end else begin
      case (r_st)
        ST_IDLE: begin
          if (w_vld) begin
            r_gnt <= w_win;
            r_gid <= u_rqst[w_win];
            r_st  <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (w_rel) begin
            r_st  <= ST_IDLE;
            r_ptr <= (r_gnt == LAST) ? '0 : r_gnt + 1'b1;
            r_gid <= ID_IDLE;
          end
        end
        default: r_st <= ST_IDLE;
      endcase
    end
  end

  assign d_rqst = ((r_st == ST_GRANT) && w_hold) ? r_gid : ID_IDLE;
  assign d_trsc = u_trsc[r_gnt];
  assign d_strb = u_strb[r_gnt];
  assign d_addr = u_addr[r_gnt];
  assign d_wdat = u_wdat[r_gnt];
  assign busy   = (r_st == ST_GRANT);

  assign u_resp = {n{d_resp}};
  assign u_miss = {n{d_miss}};
  assign u_ofst = {n{d_ofst}};
  assign u_rdat = {n{d_rdat}};

endmodule

// File: tb/tb_cache_arbiter.sv
// Randomized self-checking bench for cache_arbiter (n=4) against a
// transaction-level round-robin ownership model.
module tb_cache_arbiter;

  localparam int N   = 4;
  localparam int BLK = 16;
  localparam int DW  = BLK * 8;

  logic                    clk = 1'b0;
  logic                    rstn;
  logic [N-1:0][7:0]       u_rqst, u_trsc, u_resp, u_miss;
  logic [N-1:0][BLK-1:0]   u_strb;
  logic [N-1:0][63:0]      u_addr, u_ofst;
  logic [N-1:0][DW-1:0]    u_wdat, u_rdat;
  logic [7:0]              d_rqst, d_trsc, d_resp, d_miss;
  logic [BLK-1:0]          d_strb;
  logic [63:0]             d_addr, d_ofst;
  logic [DW-1:0]           d_wdat, d_rdat;
  logic                    busy;

  cache_arbiter #(.n(N), .blk(BLK)) dut (
    .clk(clk), .rstn(rstn),
    .u_rqst(u_rqst), .u_trsc(u_trsc), .u_strb(u_strb), .u_addr(u_addr), .u_wdat(u_wdat),
    .u_resp(u_resp), .u_miss(u_miss), .u_ofst(u_ofst), .u_rdat(u_rdat),
    .d_rqst(d_rqst), .d_trsc(d_trsc), .d_strb(d_strb), .d_addr(d_addr), .d_wdat(d_wdat),
    .d_resp(d_resp), .d_miss(d_miss), .d_ofst(d_ofst), .d_rdat(d_rdat),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Model: which port owns the channel (-1 = none), the ID it owns, next priority.
  int         m_own;
  logic [7:0] m_gid;
  int         m_ptr;

  task automatic model_reset();
    m_own = -1;
    m_gid = 8'h00;
    m_ptr = 0;
  endtask

  task automatic model_edge();
    bit found;
    if (!rstn) model_reset();
    else if (m_own < 0) begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        int p;
        p = (m_ptr + k) % N;
        if (!found && u_rqst[p] != 8'h00) begin
          found = 1'b1;
          m_own = p;
          m_gid = u_rqst[p];
        end
      end
    end else if ((m_gid != 8'h00 && d_resp == m_gid) || u_rqst[m_own] != m_gid) begin
      m_ptr = (m_own + 1) % N;
      m_own = -1;
      m_gid = 8'h00;
    end
  endtask

  task automatic check_outputs();
    int k;
    logic [7:0] exp_rq;
    exp_rq = (m_own >= 0 && u_rqst[m_own] == m_gid) ? m_gid : 8'h00;
    chk("busy", DW'(busy), DW'(m_own >= 0));
    chk("d_rqst", DW'(d_rqst), DW'(exp_rq));
    if (m_own >= 0) begin
      chk("d_addr", DW'(d_addr), DW'(u_addr[m_own]));
      chk("d_trsc", DW'(d_trsc), DW'(u_trsc[m_own]));
      chk("d_strb", DW'(d_strb), DW'(u_strb[m_own]));
      chk("d_wdat", d_wdat, u_wdat[m_own]);
    end
    k = $urandom_range(N - 1, 0);
    chk("u_resp", DW'(u_resp[k]), DW'(d_resp));
    chk("u_miss", DW'(u_miss[k]), DW'(d_miss));
    chk("u_ofst", DW'(u_ofst[k]), DW'(d_ofst));
    chk("u_rdat", u_rdat[k], d_rdat);
  endtask

  // Downstream responder and requester bookkeeping.
  logic [7:0] r_id [N];
  int         seq [N];
  logic [7:0] pend;
  int         dly;
  bit         auto_ds, soak;
  logic       prev_busy;
  int         gcnt [N];
  int         waitc [N];
  int         maxw;

  function automatic logic [7:0] new_id(input int i);
    seq[i] = seq[i] % 15 + 1;
    return {4'(i + 1), 4'(seq[i])};
  endfunction

  task automatic rand_payload();
    for (int i = 0; i < N; i++) begin
      u_trsc[i] = 8'($urandom);
      u_strb[i] = BLK'($urandom);
      u_addr[i] = {$urandom, $urandom};
      u_wdat[i] = {$urandom, $urandom, $urandom, $urandom};
    end
    d_ofst = {$urandom, $urandom};
    d_rdat = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic cyc_check();
    @(negedge clk);
    check_outputs();
    if (auto_ds && d_rqst != 8'h00 && pend == 8'h00 && d_resp != d_rqst) begin
      pend = d_rqst;
      dly  = $urandom_range(4, 1);
    end
    if (soak && busy && !prev_busy) begin
      int p;
      p = int'(d_rqst[7:4]) - 1;
      if (p >= 0 && p < N) begin
        gcnt[p]++;
        for (int q = 0; q < N; q++) begin
          if (q != p) begin
            waitc[q]++;
            if (waitc[q] > maxw) maxw = waitc[q];
          end
        end
        waitc[p] = 0;
      end
    end
    prev_busy = busy;
  endtask

  task automatic cyc_adv();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic cyc();
    cyc_check();
    cyc_adv();
  endtask

  task automatic drive_auto(input bit rnd);
    for (int i = 0; i < N; i++) begin
      if (r_id[i] != 8'h00 && d_resp == r_id[i])
        r_id[i] = (rnd && ($urandom % 2 == 0)) ? 8'h00 : new_id(i);
      else if (r_id[i] == 8'h00) begin
        if (!rnd || $urandom % 4 == 0) r_id[i] = new_id(i);
      end else if (rnd && $urandom % 24 == 0)
        r_id[i] = ($urandom % 2 == 0) ? 8'h00 : new_id(i);
      u_rqst[i] = r_id[i];
    end
    d_resp = 8'h00;
    d_miss = 8'h00;
    if (pend != 8'h00) begin
      if (dly == 0) begin
        d_resp = pend;
        d_miss = ($urandom % 2 == 0) ? 8'($urandom) : 8'h00;
        pend   = 8'h00;
      end else dly--;
    end
    if (rnd && d_resp == 8'h00 && $urandom % 6 == 0) d_resp = 8'($urandom);
    rand_payload();
  endtask

  task automatic quiesce();
    for (int i = 0; i < N; i++) r_id[i] = 8'h00;
    u_rqst = '0;
    d_resp = 8'h00;
    d_miss = 8'h00;
    pend   = 8'h00;
    repeat (3) cyc();
  endtask

  initial begin
    int gmin, gmax, gtot;
    rstn = 1'b0;
    u_rqst = '0;
    d_resp = 8'h00;
    d_miss = 8'h00;
    pend = 8'h00;
    dly = 0;
    auto_ds = 1'b0;
    soak = 1'b0;
    prev_busy = 1'b0;
    maxw = 0;
    for (int i = 0; i < N; i++) begin
      r_id[i] = 8'h00; seq[i] = 0; gcnt[i] = 0; waitc[i] = 0;
    end
    rand_payload();
    model_reset();

    cyc_check();
    chk("rst_addr", DW'(d_addr), DW'(u_addr[0]));
    cyc_adv();
    rstn = 1'b1;

    // single request: one-cycle latency, release after response
    u_rqst[1] = 8'h21;                  cyc();
    cyc_check(); chk("lat_1cyc", DW'(d_rqst), DW'(8'h21)); cyc_adv();
    cyc();
    d_resp = 8'h21;                     cyc();
    d_resp = 8'h00; u_rqst[1] = 8'h00;
    cyc_check(); chk("rel_idle", DW'(busy), DW'(1'b0)); cyc_adv();

    // contention, miss-ack release, late miss callback during next grant
    u_rqst[0] = 8'h11; u_rqst[1] = 8'h21; cyc();
    cyc_check(); chk("first_11", DW'(d_rqst), DW'(8'h11)); cyc_adv();
    d_resp = 8'h11; d_miss = 8'h05;     cyc();
    d_resp = 8'h00; d_miss = 8'h00; u_rqst[0] = 8'h00;
    cyc_check(); chk("miss_rel", DW'(busy), DW'(1'b0)); cyc_adv();
    cyc_check(); chk("second_21", DW'(d_rqst), DW'(8'h21)); cyc_adv();
    cyc(); cyc();
    d_resp = 8'h05; rand_payload();
    cyc_check();
    chk("cb_resp0", DW'(u_resp[0]), DW'(8'h05));
    chk("cb_resp1", DW'(u_resp[1]), DW'(8'h05));
    chk("cb_rdat", u_rdat[0], d_rdat);
    chk("cb_busy", DW'(busy), DW'(1'b1));
    cyc_adv();
    d_resp = 8'h21;                     cyc();
    d_resp = 8'h00; u_rqst[1] = 8'h00;
    cyc_check(); chk("cb_idle", DW'(busy), DW'(1'b0)); cyc_adv();

    // flush withdraw, then a late response that must not disturb the next grant
    u_rqst[0] = 8'h12;                  cyc();
    cyc_check(); chk("fl_grant", DW'(d_rqst), DW'(8'h12)); cyc_adv();
    u_rqst[0] = 8'h00;
    cyc_check(); chk("fl_drop", DW'(d_rqst), DW'(8'h00)); chk("fl_busy", DW'(busy), DW'(1'b1)); cyc_adv();
    u_rqst[1] = 8'h22;
    cyc_check(); chk("fl_idle", DW'(busy), DW'(1'b0)); cyc_adv();
    d_resp = 8'h12;
    cyc_check(); chk("late_bc", DW'(u_resp[3]), DW'(8'h12)); chk("late_keep", DW'(d_rqst), DW'(8'h22)); cyc_adv();
    d_resp = 8'h00;
    cyc_check(); chk("late_busy", DW'(busy), DW'(1'b1)); cyc_adv();
    d_resp = 8'h22;                     cyc();
    d_resp = 8'h00; u_rqst[1] = 8'h00;  cyc();

    // asynchronous reset in the middle of a grant
    u_rqst[2] = 8'h33;                  cyc();
    cyc_check(); chk("pre_rst", DW'(d_rqst), DW'(8'h33)); cyc_adv();
    u_rqst[0] = 8'h11;
    #2 rstn = 1'b0;
    model_reset();
    #1;
    chk("rst_rqst", DW'(d_rqst), DW'(8'h00));
    chk("rst_busy", DW'(busy), DW'(1'b0));
    cyc();
    rstn = 1'b1;                        cyc();
    cyc_check(); chk("post_rst", DW'(d_rqst), DW'(8'h11)); cyc_adv();
    d_resp = 8'h11;                     cyc();
    quiesce();

    // randomized traffic with flushes and stray callbacks
    auto_ds = 1'b1;
    repeat (1500) begin
      drive_auto(1'b1);
      cyc();
    end
    quiesce();

    // fairness soak: every port always requesting
    soak = 1'b1;
    repeat (400) begin
      drive_auto(1'b0);
      cyc();
    end
    soak = 1'b0;

    gmin = gcnt[0]; gmax = gcnt[0]; gtot = 0;
    for (int i = 0; i < N; i++) begin
      if (gcnt[i] < gmin) gmin = gcnt[i];
      if (gcnt[i] > gmax) gmax = gcnt[i];
      gtot += gcnt[i];
    end
    chk("soak_grants", DW'(gtot >= 40), DW'(1'b1));
    chk("fair_spread", DW'(gmax - gmin <= 1), DW'(1'b1));
    chk("max_wait", DW'(maxw <= N - 1), DW'(1'b1));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
